memory_cycle: RTL and testbench

Memory stage of the 5-stage RISC-V pipeline: consumes the execute stage's registered outputs, issues load/store transactions to a variable-latency data memory over a req/ready handshake, stalls the upstream pipeline while a transaction is outstanding, and drives the M/W pipeline register into writeback. Non-memory instructions pass through with one-cycle latency. A bounded-wait watchdog aborts hung transactions and raises a sticky bus-error flag.

---
 rtl/memory_cycle_pkg.sv | 47 ++++
 rtl/memory_cycle.sv | 138 +++++++++++++
 tb/tb_memory_cycle.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the memory stage: FSM state codes,
// the held memory-op payload and the M/W pipeline register payload.
package memory_cycle_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef logic [0:0] mem_state_t;
  localparam mem_state_t MEM_IDLE = 1'b0;
  localparam mem_state_t MEM_WAIT = 1'b1;

  // Everything the stage needs to finish an op after the M inputs move on.
  typedef struct packed {
    logic                  reg_write;
    logic                  result_src;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
  } mem_op_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       read_data;
  } wb_reg_t;

  localparam wb_reg_t BUBBLE = '0;

  // Builds the writeback payload for a finished op with the given load data.
  function automatic wb_reg_t to_wb(input mem_op_t op, input logic [XLEN-1:0] rdata);
    wb_reg_t w;
    w.reg_write  = op.reg_write;
    w.result_src = op.result_src;
    w.rd         = op.rd;
    w.pc_plus4   = op.pc_plus4;
    w.alu_result = op.alu_result;
    w.read_data  = rdata;
    return w;
  endfunction

endpackage

// File: rtl/memory_cycle.sv
// RISC-V memory stage: issues loads/stores over a req/ready bus, stalls the
// front of the pipe while waiting, aborts hung accesses and drives the M/W register.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int unsigned     MAX_WAIT  = 16,
  parameter logic [XLEN-1:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic                  ResultSrcM,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       WriteDataM,
  input  logic [XLEN-1:0]       ALU_ResultM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [REG_ADDR_W-1:0] RD_W,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [XLEN-1:0]       ALU_ResultW,
  output logic [XLEN-1:0]       ReadDataW,
  output logic                  BusErr
);

  mem_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t               held_q, held_d;
  wb_reg_t               w_q, w_d;
  logic                  berr_q, berr_d;

  mem_op_t         op_in_c;
  mem_op_t         cur_op_c;
  logic            cur_mem_op_c;
  logic            last_wait_c;
  logic [XLEN-1:0] load_data_c;
  logic            req_c;
  logic            stall_c;

  assign op_in_c = '{
    reg_write:  RegWriteM,
    result_src: ResultSrcM,
    mem_write:  MemWriteM,
    rd:         RD_M,
    pc_plus4:   PCPlus4M,
    alu_result: ALU_ResultM,
    write_data: WriteDataM
  };

  // In WAIT the bus is driven from the held copy so it is immune to M-input churn.
  assign cur_op_c     = (state_q == MEM_WAIT) ? held_q : op_in_c;
  assign cur_mem_op_c = cur_op_c.mem_write | cur_op_c.result_src;
  assign last_wait_c  = (cnt_q == WAIT_CNT_W'(MAX_WAIT - 1));
  assign load_data_c  = cur_op_c.mem_write ? '0 : dmem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      w_q     <= BUBBLE;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      w_q     <= w_d;
      berr_q  <= berr_d;
    end
  end

  // Next-state, watchdog and writeback selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    w_d     = BUBBLE;
    berr_d  = berr_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        held_d = op_in_c;
        if (!cur_mem_op_c) begin
          w_d = to_wb(op_in_c, '0);
        end else begin
          req_c = 1'b1;
          if (dmem_ready) begin
            w_d = to_wb(op_in_c, load_data_c);
          end else begin
            stall_c = 1'b1;
            state_d = MEM_WAIT;
            cnt_d   = '0;
          end
        end
      end
      MEM_WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          w_d     = to_wb(held_q, load_data_c);
          state_d = MEM_IDLE;
        end else if (last_wait_c) begin
          // Watchdog abort: release the pipe and retire the op with the error pattern.
          w_d     = to_wb(held_q, ERR_RDATA);
          berr_d  = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = WAIT_CNT_W'(cnt_q + WAIT_CNT_W'(1));
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign dmem_req   = req_c & rst;
  assign StallM     = stall_c & rst;
  assign dmem_we    = cur_op_c.mem_write;
  assign dmem_addr  = cur_op_c.alu_result;
  assign dmem_wdata = cur_op_c.write_data;

  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign RD_W        = w_q.rd;
  assign PCPlus4W    = w_q.pc_plus4;
  assign ALU_ResultW = w_q.alu_result;
  assign ReadDataW   = w_q.read_data;
  assign BusErr      = berr_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: a transaction-level model checked every
// cycle, plus hand-computed literal checks at the scenario landmarks.
module tb_memory_cycle;

  localparam int unsigned MW  = 4;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0;
  logic [4:0]  RD_M = '0;
  logic [31:0] PCPlus4M = '0, WriteDataM = '0, ALU_ResultM = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        StallM;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        BusErr;

  memory_cycle #(.MAX_WAIT(MW), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an op is either retired the cycle it is seen, or becomes the single
  // pending transaction that retires on ready or after MW unanswered wait cycles.
  typedef struct {
    bit        rw, rs, mw;
    bit [4:0]  rd;
    bit [31:0] pc4, alu, wd;
  } op_t;

  bit          m_pend = 0;
  op_t         m_op;
  int          m_waited = 0;
  bit          e_rw = 0, e_rs = 0, e_be = 0;
  bit [4:0]    e_rd = '0;
  bit [31:0]   e_pc = '0, e_alu = '0, e_data = '0;
  logic [31:0] txlog[$];

  op_t cur;
  bit  x_req, x_stall, done;
  bit  n_rw, n_rs;
  bit [4:0]  n_rd;
  bit [31:0] n_pc, n_alu, n_data;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(StallM), 32'd0);
      chk("rst_w", {RegWriteW, ResultSrcW, RD_W} | PCPlus4W | ALU_ResultW | ReadDataW, 32'd0);
      chk("rst_buserr", 32'(BusErr), 32'd0);
      m_pend = 0; m_waited = 0; e_be = 0;
      {e_rw, e_rs, e_rd, e_pc, e_alu, e_data} = '0;
    end else begin
      chk("m_regwrite", 32'(RegWriteW), 32'(e_rw));
      chk("m_resultsrc", 32'(ResultSrcW), 32'(e_rs));
      chk("m_rd", 32'(RD_W), 32'(e_rd));
      chk("m_pc4", PCPlus4W, e_pc);
      chk("m_alu", ALU_ResultW, e_alu);
      chk("m_rdata", ReadDataW, e_data);
      chk("m_buserr", 32'(BusErr), 32'(e_be));
      x_req = 0; x_stall = 0; done = 0;
      n_data = '0;
      if (m_pend) begin
        cur = m_op;
        x_req = 1;
        if (dmem_ready) begin
          done = 1; m_pend = 0;
          n_data = cur.mw ? 32'd0 : dmem_rdata;
        end else if (m_waited + 1 == int'(MW)) begin
          done = 1; m_pend = 0; e_be = 1;
          n_data = ERR;
        end else begin
          x_stall = 1; m_waited++;
        end
      end else begin
        cur.rw = RegWriteM; cur.rs = ResultSrcM; cur.mw = MemWriteM; cur.rd = RD_M;
        cur.pc4 = PCPlus4M; cur.alu = ALU_ResultM; cur.wd = WriteDataM;
        if (!(cur.mw || cur.rs)) begin
          done = 1;
        end else begin
          x_req = 1;
          if (dmem_ready) begin
            done = 1;
            n_data = cur.mw ? 32'd0 : dmem_rdata;
          end else begin
            x_stall = 1; m_pend = 1; m_op = cur; m_waited = 0;
          end
        end
      end
      chk("m_req", 32'(dmem_req), 32'(x_req));
      chk("m_stall", 32'(StallM), 32'(x_stall));
      if (x_req) begin
        chk("m_addr", dmem_addr, cur.alu);
        chk("m_wdata", dmem_wdata, cur.wd);
        chk("m_we", 32'(dmem_we), 32'(cur.mw));
        if (dmem_ready) txlog.push_back(dmem_addr);
      end
      if (done) begin
        n_rw = cur.rw; n_rs = cur.rs; n_rd = cur.rd; n_pc = cur.pc4; n_alu = cur.alu;
      end else begin
        n_rw = 0; n_rs = 0; n_rd = '0; n_pc = '0; n_alu = '0; n_data = '0;
      end
      {e_rw, e_rs, e_rd, e_pc, e_alu, e_data} = {n_rw, n_rs, n_rd, n_pc, n_alu, n_data};
    end
  end

  task automatic put(input bit rw, input bit rs, input bit mw, input bit [4:0] rd,
                     input bit [31:0] pc, input bit [31:0] wd, input bit [31:0] alu,
                     input bit rdy, input bit [31:0] rdata);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
    dmem_ready = rdy; dmem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    put(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
  endtask

  initial begin
    tick(); tick();
    chk("reset_alu_w", ALU_ResultW, 32'h0);
    rst = 1'b1;
    nop(); tick();

    // ALU op passes through in one cycle without touching the bus.
    put(1, 0, 0, 5'd5, 32'h104, 32'h0, 32'h10, 1'b1, 32'h0);
    #2;
    chk("alu_req", 32'(dmem_req), 32'd0);
    chk("alu_stall", 32'(StallM), 32'd0);
    tick();
    chk("alu_rw", 32'(RegWriteW), 32'd1);
    chk("alu_rd", 32'(RD_W), 32'd5);
    chk("alu_res", ALU_ResultW, 32'h10);

    // Zero-wait load.
    put(1, 1, 0, 5'd7, 32'h108, 32'h0, 32'h40, 1'b1, 32'hCAFE_F00D);
    #2;
    chk("zw_req", 32'(dmem_req), 32'd1);
    chk("zw_addr", dmem_addr, 32'h40);
    chk("zw_stall", 32'(StallM), 32'd0);
    tick();
    chk("zw_rdata", ReadDataW, 32'hCAFE_F00D);
    chk("zw_rsrc", 32'(ResultSrcW), 32'd1);

    // Store with three stalled cycles while M inputs churn.
    put(0, 0, 1, 5'd0, 32'h10C, 32'h1234, 32'h80, 1'b0, 32'h0);
    #2;
    chk("st_stall0", 32'(StallM), 32'd1);
    tick();
    chk("st_bubble0", 32'(RegWriteW) | ALU_ResultW, 32'd0);
    for (int i = 0; i < 2; i++) begin
      put(1, 1, 0, 5'd3, 32'h999, 32'hDEAD, 32'hFFFF_0000, 1'b0, 32'h0);
      #2;
      chk("st_hold_addr", dmem_addr, 32'h80);
      chk("st_hold_wdata", dmem_wdata, 32'h1234);
      chk("st_hold_we", 32'(dmem_we), 32'd1);
      chk("st_stall", 32'(StallM), 32'd1);
      tick();
      chk("st_bubble", ALU_ResultW, 32'd0);
    end
    dmem_ready = 1'b1;
    #2;
    chk("st_done_stall", 32'(StallM), 32'd0);
    tick();
    chk("st_land_alu", ALU_ResultW, 32'h80);
    chk("st_land_rdata", ReadDataW, 32'h0);
    nop(); tick();

    // Hung load aborted by the watchdog.
    put(1, 1, 0, 5'd9, 32'h110, 32'h0, 32'hC0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hung_stall", 32'(StallM), 32'd1);
      tick();
    end
    #2;
    chk("abort_stall", 32'(StallM), 32'd0);
    chk("abort_req", 32'(dmem_req), 32'd1);
    tick();
    chk("abort_rdata", ReadDataW, ERR);
    chk("abort_rd", 32'(RD_W), 32'd9);
    chk("abort_buserr", 32'(BusErr), 32'd1);
    put(1, 0, 0, 5'd2, 32'h114, 32'h0, 32'h7, 1'b0, 32'h0);
    tick();
    put(0, 0, 1, 5'd0, 32'h118, 32'h55, 32'h44, 1'b1, 32'h0);
    tick();
    chk("sticky_buserr", 32'(BusErr), 32'd1);

    // Load then store back to back, one wait each.
    txlog.delete();
    put(1, 1, 0, 5'd4, 32'h11C, 32'h0, 32'h100, 1'b0, 32'h0);
    tick();
    put(0, 0, 1, 5'd0, 32'h120, 32'h99, 32'h104, 1'b1, 32'h0000_0077);
    #2;
    chk("b2b_first_addr", dmem_addr, 32'h100);
    chk("b2b_first_we", 32'(dmem_we), 32'd0);
    tick();
    chk("b2b_load_data", ReadDataW, 32'h77);
    dmem_ready = 1'b0;
    tick();
    dmem_ready = 1'b1;
    tick();
    chk("b2b_store_alu", ALU_ResultW, 32'h104);
    nop(); tick();
    chk("b2b_count", 32'(txlog.size()), 32'd2);
    if (txlog.size() == 2) begin
      chk("b2b_order0", txlog[0], 32'h100);
      chk("b2b_order1", txlog[1], 32'h104);
    end

    // Reset in the middle of a wait drops the transaction.
    put(1, 1, 0, 5'd6, 32'h124, 32'h0, 32'h200, 1'b0, 32'h0);
    tick(); tick();
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(StallM), 32'd0);
    chk("midrst_buserr", 32'(BusErr), 32'd0);
    tick();
    rst = 1'b1;
    put(1, 1, 0, 5'd8, 32'h128, 32'h0, 32'h300, 1'b1, 32'h55AA_55AA);
    #2;
    chk("post_rst_addr", dmem_addr, 32'h300);
    chk("post_rst_stall", 32'(StallM), 32'd0);
    tick();
    chk("post_rst_rdata", ReadDataW, 32'h55AA_55AA);
    nop(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
